// File: rtl/multicycle_control_unit_v2_if.sv
// rtl/multicycle_control_unit_v2_if.sv - instruction, data bus and datapath control bundle for the multicycle control unit
interface multicycle_control_unit_v2_if;
    logic [31:0] instrCode;
    logic        busReady;
    logic        mulDone;
    logic        PCEn;
    logic        regFileWe;
    logic        aluSrcMuxSel;
    logic [3:0]  aluControl;
    logic [2:0]  RFWDSrcMuxSel;
    logic        branch;
    logic        jal;
    logic        jalr;
    logic [2:0]  strb;
    logic        busReq;
    logic        busWe;
    logic        mulStart;
    logic        instrRetired;
    logic        trap;
    logic [1:0]  trapCause;

    // control unit side
    modport master (
        input  instrCode, busReady, mulDone,
        output PCEn, regFileWe, aluSrcMuxSel, aluControl, RFWDSrcMuxSel,
               branch, jal, jalr, strb, busReq, busWe, mulStart,
               instrRetired, trap, trapCause
    );

    // datapath / ROM / bus master side
    modport slave (
        output instrCode, busReady, mulDone,
        input  PCEn, regFileWe, aluSrcMuxSel, aluControl, RFWDSrcMuxSel,
               branch, jal, jalr, strb, busReq, busWe, mulStart,
               instrRetired, trap, trapCause
    );
endinterface

// File: rtl/multicycle_control_unit_v2.sv
// rtl/multicycle_control_unit_v2.sv - multi-cycle RV32I control FSM with bus wait states, traps and optional RV32M (macro RV32M_EN)
module multicycle_control_unit_v2 #(
    parameter int BUS_TIMEOUT  = 16,
    parameter bit CHECK_FUNCT7 = 1'b1
) (
    input  logic                         clk,
    input  logic                         reset,
    multicycle_control_unit_v2_if.master bus
);
    typedef enum logic [3:0] {
        FETCH, DECODE, R_EXE, I_EXE, B_EXE, LU_EXE, AU_EXE, J_EXE, JL_EXE,
        S_EXE, S_MEM, L_EXE, L_MEM, L_WB,
`ifdef RV32M_EN
        M_EXE,
`endif
        TRAP
    } state_t;

    localparam logic [3:0] ALU_ADD       = 4'b0000;
    localparam logic [1:0] CAUSE_ILLEGAL = 2'b01;
    localparam logic [1:0] CAUSE_TIMEOUT = 2'b10;
    localparam logic [7:0] CNT_LIMIT     = 8'(BUS_TIMEOUT - 1);

    localparam logic [6:0] OP_R  = 7'b0110011;
    localparam logic [6:0] OP_I  = 7'b0010011;
    localparam logic [6:0] OP_B  = 7'b1100011;
    localparam logic [6:0] OP_LU = 7'b0110111;
    localparam logic [6:0] OP_AU = 7'b0010111;
    localparam logic [6:0] OP_J  = 7'b1101111;
    localparam logic [6:0] OP_JL = 7'b1100111;
    localparam logic [6:0] OP_S  = 7'b0100011;
    localparam logic [6:0] OP_L  = 7'b0000011;

    // {PCEn, regFileWe, aluSrcMuxSel, busWe, RFWDSrcMuxSel[2:0], branch, jal, jalr}
    localparam logic [9:0] CTRL_FETCH = 10'b1000_000_000;
    localparam logic [9:0] CTRL_R     = 10'b0100_000_000;
    localparam logic [9:0] CTRL_I     = 10'b0110_000_000;
    localparam logic [9:0] CTRL_B     = 10'b0000_000_100;
    localparam logic [9:0] CTRL_LU    = 10'b0100_010_000;
    localparam logic [9:0] CTRL_AU    = 10'b0100_011_000;
    localparam logic [9:0] CTRL_J     = 10'b0100_100_010;
    localparam logic [9:0] CTRL_JL    = 10'b0110_100_011;
    localparam logic [9:0] CTRL_S     = 10'b0010_000_000;
    localparam logic [9:0] CTRL_SMEM  = 10'b0011_000_000;
    localparam logic [9:0] CTRL_L     = 10'b0010_001_000;
    localparam logic [9:0] CTRL_LWB   = 10'b0110_001_000;

    state_t      state;
    state_t      state_next;
    logic [7:0]  counter;
    logic [1:0]  cause_q;
    logic [1:0]  cause_next;
    logic [9:0]  ctrl;
    logic        bus_req;
    logic [3:0]  alu_control;
    logic        retired;
    logic        mul_start;

    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic        funct7_base;
    logic        r_illegal;
    logic        unused_bits;

    assign opcode      = bus.instrCode[6:0];
    assign funct3      = bus.instrCode[14:12];
    assign funct7      = bus.instrCode[31:25];
    assign funct7_base = (funct7 == 7'b0000000) || (funct7 == 7'b0100000);

`ifdef RV32M_EN
    logic r_is_m;
    logic mul_busy;
    assign r_is_m      = (funct7 == 7'b0000001);
    assign r_illegal   = CHECK_FUNCT7 && !funct7_base && !r_is_m;
    assign unused_bits = ^{bus.instrCode[24:15], bus.instrCode[11:7]};
`else
    assign r_illegal   = CHECK_FUNCT7 && !funct7_base;
    assign unused_bits = ^{bus.instrCode[24:15], bus.instrCode[11:7], bus.mulDone};
`endif

    // state, trap cause and bus wait counter registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= FETCH;
            counter <= 8'd0;
            cause_q <= 2'b00;
        end else begin
            state   <= state_next;
            cause_q <= cause_next;
            if (state == S_EXE || state == L_EXE)
                counter <= 8'd0;
            else if ((state == S_MEM || state == L_MEM) && !bus.busReady)
                counter <= counter + 8'd1;
        end
    end

`ifdef RV32M_EN
    // remembers that the start pulse for the current M instruction was already issued
    always_ff @(posedge clk) begin
        if (reset)
            mul_busy <= 1'b0;
        else
            mul_busy <= (state == M_EXE) && !bus.mulDone;
    end
`endif

    // next-state and Moore outputs, with the handshake-qualified retire/writeback
    always_comb begin
        state_next  = state;
        cause_next  = cause_q;
        ctrl        = '0;
        bus_req     = 1'b0;
        alu_control = ALU_ADD;
        retired     = 1'b0;
        mul_start   = 1'b0;
        case (state)
            FETCH: begin
                ctrl       = CTRL_FETCH;
                state_next = DECODE;
            end
            DECODE: begin
                case (opcode)
                    OP_R: begin
                        if (r_illegal) begin
                            state_next = TRAP;
                            cause_next = CAUSE_ILLEGAL;
                        end
`ifdef RV32M_EN
                        else if (r_is_m)
                            state_next = M_EXE;
`endif
                        else
                            state_next = R_EXE;
                    end
                    OP_I:  state_next = I_EXE;
                    OP_B:  state_next = B_EXE;
                    OP_LU: state_next = LU_EXE;
                    OP_AU: state_next = AU_EXE;
                    OP_J:  state_next = J_EXE;
                    OP_JL: state_next = JL_EXE;
                    OP_S:  state_next = S_EXE;
                    OP_L:  state_next = L_EXE;
                    default: begin
                        state_next = TRAP;
                        cause_next = CAUSE_ILLEGAL;
                    end
                endcase
            end
            R_EXE: begin
                ctrl        = CTRL_R;
                alu_control = {bus.instrCode[30], funct3};
                retired     = 1'b1;
                state_next  = FETCH;
            end
            I_EXE: begin
                ctrl        = CTRL_I;
                // only the shift-right immediates carry an op bit in instr[30]
                alu_control = (funct3 == 3'b101) ? {bus.instrCode[30], funct3} : {1'b0, funct3};
                retired     = 1'b1;
                state_next  = FETCH;
            end
            B_EXE: begin
                ctrl        = CTRL_B;
                alu_control = {1'b0, funct3};
                retired     = 1'b1;
                state_next  = FETCH;
            end
            LU_EXE: begin
                ctrl       = CTRL_LU;
                retired    = 1'b1;
                state_next = FETCH;
            end
            AU_EXE: begin
                ctrl       = CTRL_AU;
                retired    = 1'b1;
                state_next = FETCH;
            end
            J_EXE: begin
                ctrl       = CTRL_J;
                retired    = 1'b1;
                state_next = FETCH;
            end
            JL_EXE: begin
                ctrl       = CTRL_JL;
                retired    = 1'b1;
                state_next = FETCH;
            end
            S_EXE: begin
                ctrl       = CTRL_S;
                state_next = S_MEM;
            end
            S_MEM: begin
                ctrl    = CTRL_SMEM;
                bus_req = 1'b1;
                // a ready in the limit cycle still completes the access
                if (bus.busReady) begin
                    retired    = 1'b1;
                    state_next = FETCH;
                end else if (counter >= CNT_LIMIT) begin
                    state_next = TRAP;
                    cause_next = CAUSE_TIMEOUT;
                end
            end
            L_EXE: begin
                ctrl       = CTRL_L;
                state_next = L_MEM;
            end
            L_MEM: begin
                ctrl    = CTRL_L;
                bus_req = 1'b1;
                if (bus.busReady) begin
                    state_next = L_WB;
                end else if (counter >= CNT_LIMIT) begin
                    state_next = TRAP;
                    cause_next = CAUSE_TIMEOUT;
                end
            end
            L_WB: begin
                ctrl       = CTRL_LWB;
                retired    = 1'b1;
                state_next = FETCH;
            end
`ifdef RV32M_EN
            M_EXE: begin
                mul_start = !mul_busy;
                if (bus.mulDone) begin
                    ctrl       = 10'b0100_101_000;
                    retired    = 1'b1;
                    state_next = FETCH;
                end
            end
`endif
            TRAP: begin
                state_next = TRAP;
            end
            default: begin
                state_next = FETCH;
            end
        endcase
        // reset forces the quiet output pattern in the reset cycle itself
        if (reset) begin
            ctrl        = '0;
            bus_req     = 1'b0;
            alu_control = ALU_ADD;
            retired     = 1'b0;
            mul_start   = 1'b0;
        end
    end

    assign {bus.PCEn, bus.regFileWe, bus.aluSrcMuxSel, bus.busWe,
            bus.RFWDSrcMuxSel, bus.branch, bus.jal, bus.jalr} = ctrl;
    assign bus.busReq       = bus_req;
    assign bus.aluControl   = alu_control;
    assign bus.instrRetired = retired;
    assign bus.mulStart     = mul_start;
    assign bus.strb         = reset ? 3'b000 : funct3;
    assign bus.trap         = (state == TRAP) && !reset;
    assign bus.trapCause    = reset ? 2'b00 : cause_q;
endmodule

// File: tb/tb_multicycle_control_unit_v2.sv
// tb/tb_multicycle_control_unit_v2.sv - randomized self-checking bench for multicycle_control_unit_v2
module tb_multicycle_control_unit_v2;
    localparam int BUS_TIMEOUT  = 16;
    localparam bit CHECK_FUNCT7 = 1'b1;
`ifdef RV32M_EN
    localparam bit M_EN = 1'b1;
`else
    localparam bit M_EN = 1'b0;
`endif

    localparam logic [9:0] C_ZERO  = 10'b0000_000_000;
    localparam logic [9:0] C_FETCH = 10'b1000_000_000;
    localparam logic [9:0] C_R     = 10'b0100_000_000;
    localparam logic [9:0] C_I     = 10'b0110_000_000;
    localparam logic [9:0] C_B     = 10'b0000_000_100;
    localparam logic [9:0] C_LU    = 10'b0100_010_000;
    localparam logic [9:0] C_AU    = 10'b0100_011_000;
    localparam logic [9:0] C_J     = 10'b0100_100_010;
    localparam logic [9:0] C_JL    = 10'b0110_100_011;
    localparam logic [9:0] C_S     = 10'b0010_000_000;
    localparam logic [9:0] C_SMEM  = 10'b0011_000_000;
    localparam logic [9:0] C_L     = 10'b0010_001_000;
    localparam logic [9:0] C_LWB   = 10'b0110_001_000;
    localparam logic [9:0] C_MUL   = 10'b0100_101_000;
    localparam logic [3:0] ADD     = 4'b0000;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    multicycle_control_unit_v2_if bus_if ();

    multicycle_control_unit_v2 #(
        .BUS_TIMEOUT (BUS_TIMEOUT),
        .CHECK_FUNCT7(CHECK_FUNCT7)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus_if)
    );

    int checks = 0;
    int errors = 0;

    logic [31:0] exp_q [$];
    bit          rdy_q [$];
    bit          md_q  [$];
    string       tag_q [$];
    logic [2:0]  cur_strb;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] observe();
        return {9'b0, bus_if.strb, bus_if.PCEn, bus_if.regFileWe, bus_if.aluSrcMuxSel,
                bus_if.busWe, bus_if.RFWDSrcMuxSel, bus_if.branch, bus_if.jal, bus_if.jalr,
                bus_if.busReq, bus_if.aluControl, bus_if.mulStart, bus_if.instrRetired,
                bus_if.trap, bus_if.trapCause};
    endfunction

    function automatic logic [31:0] vec(input logic [9:0] ctrl, input logic breq,
                                        input logic [3:0] alu, input logic ms,
                                        input logic ret, input logic tr, input logic [1:0] cause);
        return {9'b0, cur_strb, ctrl, breq, alu, ms, ret, tr, cause};
    endfunction

    function automatic bit rnd();
        return 1'($urandom_range(0, 1));
    endfunction

    task automatic push(input string tag, input logic [31:0] v, input bit rdy, input bit md);
        tag_q.push_back(tag);
        exp_q.push_back(v);
        rdy_q.push_back(rdy);
        md_q.push_back(md);
    endtask

    task automatic trap_tail(input logic [1:0] cause, output bit trapped);
        for (int k = 0; k < 3; k++)
            push("trap", vec(C_ZERO, 1'b0, ADD, 1'b0, 1'b0, 1'b1, cause), rnd(), rnd());
        trapped = 1'b1;
    endtask

    // bus phase of a load/store: wait_n idle cycles then ready, or timeout trap
    task automatic mem_phase(input logic [9:0] ctrl, input bit is_store, input int wait_n,
                             output bit trapped);
        trapped = 1'b0;
        for (int k = 0; k < BUS_TIMEOUT; k++) begin
            if (k == wait_n) begin
                push("mem_done", vec(ctrl, 1'b1, ADD, 1'b0, is_store, 1'b0, 2'b00), 1'b1, rnd());
                break;
            end
            push("mem_wait", vec(ctrl, 1'b1, ADD, 1'b0, 1'b0, 1'b0, 2'b00), 1'b0, rnd());
        end
        if (wait_n >= BUS_TIMEOUT)
            trap_tail(2'b10, trapped);
    endtask

    // reference: expected per-cycle outputs of one instruction from the ISA rules
    task automatic expect_instr(input logic [31:0] ins, input int wait_n, output bit trapped);
        logic [6:0] op;
        logic [2:0] f3;
        logic [6:0] f7;
        logic       b30;
        bit         t;
        op  = ins[6:0];
        f3  = ins[14:12];
        f7  = ins[31:25];
        b30 = ins[30];
        cur_strb = f3;
        trapped  = 1'b0;
        push("fetch",  vec(C_FETCH, 1'b0, ADD, 1'b0, 1'b0, 1'b0, 2'b00), rnd(), rnd());
        push("decode", vec(C_ZERO,  1'b0, ADD, 1'b0, 1'b0, 1'b0, 2'b00), rnd(), rnd());
        case (op)
            7'b0110011: begin
                if (M_EN && f7 == 7'h01) begin
                    for (int k = 0; k <= wait_n; k++)
                        push((k == wait_n) ? "m_done" : "m_wait",
                             vec((k == wait_n) ? C_MUL : C_ZERO, 1'b0, ADD, k == 0, k == wait_n,
                                 1'b0, 2'b00), rnd(), k == wait_n);
                end else if (f7 == 7'h00 || f7 == 7'h20 || !CHECK_FUNCT7) begin
                    push("r_exe", vec(C_R, 1'b0, {b30, f3}, 1'b0, 1'b1, 1'b0, 2'b00), rnd(), rnd());
                end else begin
                    trap_tail(2'b01, trapped);
                end
            end
            7'b0010011: push("i_exe", vec(C_I, 1'b0, (f3 == 3'b101) ? {b30, f3} : {1'b0, f3},
                                          1'b0, 1'b1, 1'b0, 2'b00), rnd(), rnd());
            7'b1100011: push("b_exe",  vec(C_B,  1'b0, {1'b0, f3}, 1'b0, 1'b1, 1'b0, 2'b00), rnd(), rnd());
            7'b0110111: push("lu_exe", vec(C_LU, 1'b0, ADD, 1'b0, 1'b1, 1'b0, 2'b00), rnd(), rnd());
            7'b0010111: push("au_exe", vec(C_AU, 1'b0, ADD, 1'b0, 1'b1, 1'b0, 2'b00), rnd(), rnd());
            7'b1101111: push("j_exe",  vec(C_J,  1'b0, ADD, 1'b0, 1'b1, 1'b0, 2'b00), rnd(), rnd());
            7'b1100111: push("jl_exe", vec(C_JL, 1'b0, ADD, 1'b0, 1'b1, 1'b0, 2'b00), rnd(), rnd());
            7'b0100011: begin
                push("s_exe", vec(C_S, 1'b0, ADD, 1'b0, 1'b0, 1'b0, 2'b00), rnd(), rnd());
                mem_phase(C_SMEM, 1'b1, wait_n, t);
                trapped = t;
            end
            7'b0000011: begin
                push("l_exe", vec(C_L, 1'b0, ADD, 1'b0, 1'b0, 1'b0, 2'b00), rnd(), rnd());
                mem_phase(C_L, 1'b0, wait_n, t);
                trapped = t;
                if (!t)
                    push("l_wb", vec(C_LWB, 1'b0, ADD, 1'b0, 1'b1, 1'b0, 2'b00), rnd(), rnd());
            end
            default: trap_tail(2'b01, trapped);
        endcase
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        reset = 1'b1;
        bus_if.busReady = rnd();
        bus_if.mulDone  = rnd();
        #1;
        check("reset", observe(), 32'h0);
    endtask

    task automatic run_seq();
        while (exp_q.size() > 0) begin
            @(posedge clk);
            #1;
            reset = 1'b0;
            bus_if.busReady = rdy_q.pop_front();
            bus_if.mulDone  = md_q.pop_front();
            #1;
            check(tag_q.pop_front(), observe(), exp_q.pop_front());
        end
    endtask

    // cut > 0 truncates the instruction after that many cycles and resets mid-flight
    task automatic run_instr(input logic [31:0] ins, input int wait_n, input int cut);
        bit tr;
        bus_if.instrCode = ins;
        expect_instr(ins, wait_n, tr);
        if (cut > 0) begin
            while (exp_q.size() > cut) begin
                void'(exp_q.pop_back());
                void'(rdy_q.pop_back());
                void'(md_q.pop_back());
                void'(tag_q.pop_back());
            end
        end
        run_seq();
        if (tr || cut > 0)
            do_reset();
    endtask

    function automatic logic [31:0] rand_instr();
        logic [31:0] ins;
        ins = $urandom();
        case ($urandom_range(0, 10))
            0: begin
                ins[6:0] = 7'b0110011;
                case ($urandom_range(0, 3))
                    0: ins[31:25] = 7'h00;
                    1: ins[31:25] = 7'h20;
                    2: ins[31:25] = 7'h01;
                    default: ;
                endcase
            end
            1:  ins[6:0] = 7'b0010011;
            2:  ins[6:0] = 7'b1100011;
            3:  ins[6:0] = 7'b0110111;
            4:  ins[6:0] = 7'b0010111;
            5:  ins[6:0] = 7'b1101111;
            6:  ins[6:0] = 7'b1100111;
            7:  ins[6:0] = 7'b0100011;
            8:  ins[6:0] = 7'b0000011;
            9:  ;
            default: begin
                ins[6:0]   = 7'b0110011;
                ins[31:25] = 7'h01;
            end
        endcase
        return ins;
    endfunction

    initial begin
        logic [31:0] ins;
        bus_if.instrCode = 32'h0;
        bus_if.busReady  = 1'b0;
        bus_if.mulDone   = 1'b0;
        do_reset();
        run_instr(32'h003100B3, 0, 0);           // ADD x1,x2,x3
        run_instr(32'h00112023, 3, 0);           // SW, three wait states
        run_instr(32'h0000A083, 1000, 0);        // LW, bus never ready -> timeout
        run_instr(32'h0000007F, 0, 0);           // illegal opcode
        run_instr(32'h4010D093, 0, 0);           // SRAI
        run_instr(32'h40008093, 0, 0);           // ADDI with instr[30] set
        run_instr(32'h023100B3, 5, 0);           // MUL
        run_instr(32'h00112023, 1000, 5);        // SW reset during S_MEM
        run_instr(32'h0000A083, BUS_TIMEOUT - 1, 0); // ready in limit cycle
        run_instr(32'h00112023, BUS_TIMEOUT, 0);     // ready one cycle too late
        run_instr(32'h0000A083, 1000, 8);        // LW reset during L_MEM
        run_instr(32'h0000A083, 2, 0);
        for (int n = 0; n < 80; n++) begin
            ins = rand_instr();
            if (ins[6:0] == 7'b0110011)
                run_instr(ins, $urandom_range(0, 6), 0);
            else
                run_instr(ins, $urandom_range(0, BUS_TIMEOUT + 4), ($urandom_range(0, 9) == 0) ? 4 : 0);
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
